// File: rtl/rule_packer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// rule_packer : drops zero rule-ID slots and packs survivors densely (rev 1.0)
// ---------------------------------------------------------------------------
module rule_packer #(
  parameter int NUM_SLOTS = 8,
  parameter int SLOT_W    = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_SLOTS*SLOT_W-1:0] in_usr_data,
  input  logic                        in_usr_valid,
  input  logic                        in_usr_sop,
  input  logic                        in_usr_eop,
  input  logic [3:0]                  in_usr_empty,
  output logic                        in_usr_ready,
  output logic [NUM_SLOTS*SLOT_W-1:0] out_usr_data,
  output logic                        out_usr_valid,
  output logic                        out_usr_sop,
  output logic                        out_usr_eop,
  output logic [3:0]                  out_usr_empty,
  input  logic                        out_usr_ready,
  output logic [31:0]                 rule_cnt,
  output logic [31:0]                 pkt_cnt
);

  localparam logic [0:0] S_RUN   = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  logic [0:0]                       state_q, state_d;
  logic [NUM_SLOTS-1:0][SLOT_W-1:0] res_q, res_d;
  logic [3:0]                       res_cnt_q, res_cnt_d;
  logic                             first_q, first_d;
  logic                             out_valid_q, out_valid_d;
  logic                             out_sop_q, out_sop_d;
  logic                             out_eop_q, out_eop_d;
  logic [3:0]                       out_empty_q, out_empty_d;
  logic [NUM_SLOTS-1:0][SLOT_W-1:0] out_data_q, out_data_d;
  logic [31:0]                      rule_cnt_q, rule_cnt_d;
  logic [31:0]                      pkt_cnt_q, pkt_cnt_d;

  logic [2*NUM_SLOTS-1:0][SLOT_W-1:0] cat;
  logic [4:0]                         tot;
  logic [3:0]                         nz_cnt;
  logic                               in_acc;
  logic [2:0]                         run_gap;
  logic [2:0]                         flush_gap;
  logic                               unused_inputs;

  // Framing derives from eop alone; input sop and empty carry no information here.
  assign unused_inputs = ^{in_usr_sop, in_usr_empty};

  assign in_usr_ready = (state_q == S_RUN) & (~out_valid_q | out_usr_ready);
  assign in_acc       = in_usr_valid & in_usr_ready;

  // Residue first, then this beat's nonzero slots in ascending order; unused tail stays zero.
  always_comb begin
    cat    = '0;
    nz_cnt = '0;
    for (int i = 0; i < NUM_SLOTS; i++) begin
      if (4'(i) < res_cnt_q) cat[i] = res_q[i];
    end
    tot = {1'b0, res_cnt_q};
    for (int k = 0; k < NUM_SLOTS; k++) begin
      if (in_usr_data[k*SLOT_W +: SLOT_W] != '0) begin
        cat[tot[3:0]] = in_usr_data[k*SLOT_W +: SLOT_W];
        tot           = tot + 5'd1;
        nz_cnt        = nz_cnt + 4'd1;
      end
    end
  end

  assign run_gap   = 3'(5'd8 - tot);
  assign flush_gap = 3'(4'd8 - res_cnt_q);

  always_comb begin
    state_d     = state_q;
    res_d       = res_q;
    res_cnt_d   = res_cnt_q;
    first_d     = first_q;
    out_valid_d = out_valid_q & ~out_usr_ready;
    out_sop_d   = out_sop_q;
    out_eop_d   = out_eop_q;
    out_empty_d = out_empty_q;
    out_data_d  = out_data_q;
    rule_cnt_d  = rule_cnt_q;
    pkt_cnt_d   = pkt_cnt_q;

    if (state_q == S_FLUSH) begin
      // A beat is always pending here; the leftover loads as soon as it leaves.
      if (out_usr_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = res_q;
        out_sop_d   = first_q;
        out_eop_d   = 1'b1;
        out_empty_d = {flush_gap, 1'b0};
        first_d     = 1'b1;
        res_d       = '0;
        res_cnt_d   = '0;
        state_d     = S_RUN;
      end
    end else if (in_acc) begin
      rule_cnt_d = rule_cnt_q + 32'(nz_cnt);
      pkt_cnt_d  = pkt_cnt_q + 32'(in_usr_eop);
      if (in_usr_eop) begin
        out_valid_d = 1'b1;
        out_data_d  = cat[NUM_SLOTS-1:0];
        out_sop_d   = first_q;
        if (tot > 5'd8) begin
          out_eop_d   = 1'b0;
          out_empty_d = 4'd0;
          first_d     = 1'b0;
          res_d       = cat[2*NUM_SLOTS-1:NUM_SLOTS];
          res_cnt_d   = {1'b0, tot[2:0]};
          state_d     = S_FLUSH;
        end else begin
          out_eop_d   = 1'b1;
          out_empty_d = (tot == 5'd0) ? 4'd0 : {run_gap, 1'b0};
          first_d     = 1'b1;
          res_d       = '0;
          res_cnt_d   = '0;
        end
      end else if (tot >= 5'd8) begin
        out_valid_d = 1'b1;
        out_data_d  = cat[NUM_SLOTS-1:0];
        out_sop_d   = first_q;
        out_eop_d   = 1'b0;
        out_empty_d = 4'd0;
        first_d     = 1'b0;
        res_d       = cat[2*NUM_SLOTS-1:NUM_SLOTS];
        res_cnt_d   = {1'b0, tot[2:0]};
      end else begin
        res_d     = cat[NUM_SLOTS-1:0];
        res_cnt_d = tot[3:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_RUN;
      res_q       <= '0;
      res_cnt_q   <= '0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      out_data_q  <= '0;
      rule_cnt_q  <= '0;
      pkt_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      res_q       <= res_d;
      res_cnt_q   <= res_cnt_d;
      first_q     <= first_d;
      out_valid_q <= out_valid_d;
      out_sop_q   <= out_sop_d;
      out_eop_q   <= out_eop_d;
      out_empty_q <= out_empty_d;
      out_data_q  <= out_data_d;
      rule_cnt_q  <= rule_cnt_d;
      pkt_cnt_q   <= pkt_cnt_d;
    end
  end

  assign out_usr_data  = out_data_q;
  assign out_usr_valid = out_valid_q;
  assign out_usr_sop   = out_sop_q;
  assign out_usr_eop   = out_eop_q;
  assign out_usr_empty = out_empty_q;
  assign rule_cnt      = rule_cnt_q;
  assign pkt_cnt       = pkt_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_rule_packer.sv
`default_nettype none
// tb_rule_packer : directed and random packets against a rule-queue scoreboard.
module tb_rule_packer;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] in_data;
  logic         in_valid, in_sop, in_eop;
  logic [3:0]   in_empty;
  logic         in_ready;
  logic [127:0] out_data;
  logic         out_valid, out_sop, out_eop;
  logic [3:0]   out_empty;
  logic         out_ready;
  logic [31:0]  rule_cnt, pkt_cnt;

  typedef struct {
    logic [127:0] d;
    logic         s;
    logic         e;
    logic [3:0]   emp;
  } beat_t;

  beat_t        exp_q[$];
  logic [15:0]  rq[$];
  logic         m_first;
  int unsigned  m_rules, m_pkts;
  int           total = 0;
  int           bad   = 0;
  bit           rand_rdy = 1'b0;

  rule_packer dut (
    .clk          (clk),
    .rst          (rst),
    .in_usr_data  (in_data),
    .in_usr_valid (in_valid),
    .in_usr_sop   (in_sop),
    .in_usr_eop   (in_eop),
    .in_usr_empty (in_empty),
    .in_usr_ready (in_ready),
    .out_usr_data (out_data),
    .out_usr_valid(out_valid),
    .out_usr_sop  (out_sop),
    .out_usr_eop  (out_eop),
    .out_usr_empty(out_empty),
    .out_usr_ready(out_ready),
    .rule_cnt     (rule_cnt),
    .pkt_cnt      (pkt_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [127:0] d, input logic s, input logic e);
    bit acc;
    int n;
    in_data = d; in_sop = s; in_eop = e; in_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 1000) begin
      @(negedge clk);
      acc = in_ready;
      tick();
      n++;
    end
    chk("send_accepted", 128'(acc), 128'(1'b1));
    in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
  endtask

  task automatic emit(input int n, input logic e);
    beat_t b;
    b.d = '0;
    for (int i = 0; i < n; i++) b.d[16*i +: 16] = rq.pop_front();
    b.s   = m_first;
    b.e   = e;
    b.emp = (n == 0) ? 4'd0 : 4'(2 * (8 - n));
    m_first = e;
    exp_q.push_back(b);
  endtask

  task automatic check_out(input string tag, input logic [127:0] d, input logic s,
                           input logic e, input logic [3:0] emp);
    chk({tag, "_valid"}, 128'(out_valid), 128'(1'b1));
    chk({tag, "_data"},  out_data, d);
    chk({tag, "_sop"},   128'(out_sop), 128'(s));
    chk({tag, "_eop"},   128'(out_eop), 128'(e));
    chk({tag, "_empty"}, 128'(out_empty), 128'(emp));
  endtask

  // Scoreboard: model counters and expected beats, compared at the falling edge.
  initial begin
    logic [134:0] snap;
    bit           stall_prev;
    beat_t        b;
    m_first = 1'b1; m_rules = 0; m_pkts = 0; stall_prev = 1'b0; snap = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        rq.delete(); exp_q.delete();
        m_first = 1'b1; m_rules = 0; m_pkts = 0; stall_prev = 1'b0;
      end else begin
        chk("rule_cnt", 128'(rule_cnt), 128'(m_rules));
        chk("pkt_cnt",  128'(pkt_cnt),  128'(m_pkts));
        if (stall_prev)
          chk("stall_stable", 128'({out_valid, out_sop, out_eop, out_empty, out_data}), 128'(snap));
        if (out_valid && out_ready) begin
          chk("beat_expected", 128'(exp_q.size() != 0), 128'(1'b1));
          if (exp_q.size() != 0) begin
            b = exp_q.pop_front();
            chk("sb_data",  out_data, b.d);
            chk("sb_sop",   128'(out_sop), 128'(b.s));
            chk("sb_eop",   128'(out_eop), 128'(b.e));
            chk("sb_empty", 128'(out_empty), 128'(b.emp));
          end
        end
        stall_prev = out_valid && !out_ready;
        snap = {out_valid, out_sop, out_eop, out_empty, out_data};
        if (in_valid && in_ready) begin
          for (int k = 0; k < 8; k++) begin
            if (in_data[16*k +: 16] != 16'd0) begin
              rq.push_back(in_data[16*k +: 16]);
              m_rules++;
            end
          end
          if (in_eop) begin
            m_pkts++;
            if (rq.size() == 0) emit(0, 1'b1);
            else begin
              while (rq.size() > 8) emit(8, 1'b0);
              emit(rq.size(), 1'b1);
            end
          end else begin
            while (rq.size() >= 8) emit(8, 1'b0);
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog timeout total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d;
    int           nb, dens;
    rst = 1'b1; in_data = '0; in_valid = 1'b0; in_sop = 1'b0; in_eop = 1'b0;
    in_empty = 4'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_data",  out_data, 128'd0);
    chk("rst_flags", 128'({out_sop, out_eop, out_empty}), 128'(6'd0));
    chk("rst_cnts",  128'({rule_cnt, pkt_cnt}), 128'(64'd0));
    chk("rst_ready", 128'(in_ready), 128'(1'b1));
    rst = 1'b0;

    // Single-beat packet with holes.
    send(128'h0009_0000_0000_0000_0000_0007_0000_0005, 1'b1, 1'b1);
    check_out("t1", 128'h0000_0000_0000_0000_0000_0009_0007_0005, 1'b1, 1'b1, 4'd10);
    chk("t1_rule_cnt", 128'(rule_cnt), 128'(32'd3));
    chk("t1_pkt_cnt",  128'(pkt_cnt),  128'(32'd1));

    // Three beats: 5, 5, 0 nonzero slots.
    send(128'h0005_0000_0004_0000_0003_0002_0000_0001, 1'b1, 1'b0);
    send(128'h000a_0000_0009_0008_0000_0007_0006_0000, 1'b0, 1'b0);
    check_out("t2a", 128'h0008_0007_0006_0005_0004_0003_0002_0001, 1'b1, 1'b0, 4'd0);
    send(128'd0, 1'b0, 1'b1);
    check_out("t2b", 128'h0000_0000_0000_0000_0000_0000_000a_0009, 1'b0, 1'b1, 4'd12);

    // Eop beat gives t=13: full beat then a flush beat, one lost input cycle.
    send(128'h0015_0014_0000_0013_0000_0012_0011_0000, 1'b1, 1'b0);
    send(128'h0028_0027_0026_0025_0024_0023_0022_0021, 1'b0, 1'b1);
    check_out("t3a", 128'h0023_0022_0021_0015_0014_0013_0012_0011, 1'b1, 1'b0, 4'd0);
    chk("t3_ready_low", 128'(in_ready), 128'(1'b0));
    tick();
    chk("t3_ready_back", 128'(in_ready), 128'(1'b1));
    check_out("t3b", 128'h0000_0000_0000_0028_0027_0026_0025_0024, 1'b0, 1'b1, 4'd6);

    // Zero-rule packet.
    send(128'd0, 1'b1, 1'b0);
    chk("t4_no_early_beat", 128'(out_valid), 128'(1'b0));
    send(128'd0, 1'b0, 1'b1);
    check_out("t4", 128'd0, 1'b1, 1'b1, 4'd0);
    tick();
    chk("t4_rule_cnt", 128'(rule_cnt), 128'(32'd26));
    chk("t4_pkt_cnt",  128'(pkt_cnt),  128'(32'd4));

    // Reset mid-packet with residue 3 and a pending output beat.
    out_ready = 1'b0;
    send(128'h0000_0033_0000_0032_0000_0000_0031_0000, 1'b1, 1'b0);
    send(128'h0048_0047_0046_0045_0044_0043_0042_0041, 1'b0, 1'b0);
    chk("t5_pending", 128'(out_valid), 128'(1'b1));
    #2;
    rst = 1'b1;
    #1;
    chk("t5_async_valid", 128'(out_valid), 128'(1'b0));
    chk("t5_async_data",  out_data, 128'd0);
    chk("t5_async_flags", 128'({out_sop, out_eop, out_empty}), 128'(6'd0));
    chk("t5_async_cnts",  128'({rule_cnt, pkt_cnt}), 128'(64'd0));
    tick();
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    send(128'h0000_0000_0078_0000_0000_0000_0000_0077, 1'b1, 1'b1);
    check_out("t5_after", 128'h0000_0000_0000_0000_0000_0000_0078_0077, 1'b1, 1'b1, 4'd12);
    chk("t5_rule_cnt", 128'(rule_cnt), 128'(32'd2));

    // Random packets under 50% output backpressure.
    rand_rdy = 1'b1;
    for (int p = 0; p < 200; p++) begin
      nb   = $urandom_range(1, 4);
      dens = (p % 10 == 0) ? 0 : $urandom_range(0, 100);
      for (int b = 0; b < nb; b++) begin
        d = '0;
        for (int k = 0; k < 8; k++)
          if ($urandom_range(0, 99) < dens) d[16*k +: 16] = 16'($urandom_range(1, 65535));
        send(d, b == 0, b == nb - 1);
      end
    end
    rand_rdy = 1'b0;
    out_ready = 1'b1;
    repeat (5) tick();
    chk("drain_empty", 128'(exp_q.size()), 128'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/rule_packer.md
Name: rule_packer

Overview:
- Sits directly downstream of the port-group rule FIFO.
- Input beats carry 8 × 16-bit rule-ID slots; a zero slot means "no rule" and is a hole left by port-group filtering.
- The block removes the zero slots and packs the surviving rule IDs densely into 128-bit output beats, preserving packet framing (sop/eop/empty), so the downstream non-fast-pattern matcher never spends cycles on holes.

Parameters:
- NUM_SLOTS, 8, rule slots per beat. Fixed; the RTL need only support 8.
- SLOT_W, 16, bits per slot. Fixed; the RTL need only support 16.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- in_usr_data  in  128  slot k at bits [16k+15:16k]
- in_usr_valid  in  1  input beat valid
- in_usr_sop  in  1  first beat of packet
- in_usr_eop  in  1  last beat of packet
- in_usr_empty  in  4  ignored; zero slots are dropped regardless
- in_usr_ready  out  1  block accepts beat this cycle
- out_usr_data  out  128  packed rule IDs; slot 0 = oldest
- out_usr_valid  out  1  output beat valid
- out_usr_sop  out  1  first output beat of packet
- out_usr_eop  out  1  last output beat of packet
- out_usr_empty  out  4  unused bytes in beat = 2×(8−n), n = rules in beat
- out_usr_ready  in  1  downstream accepts beat
- rule_cnt  out  32  total nonzero slots accepted
- pkt_cnt  out  32  total input eop beats accepted

Behaviour:
- Reset (async, rst=1): all of the following clear immediately; any partial packet is discarded, and no flush beat is emitted after reset deasserts.
  - out_usr_valid/sop/eop = 0, out_usr_data = 0, out_usr_empty = 0
  - rule_cnt = pkt_cnt = 0
  - residue count = 0, first-beat flag = 1, state = RUN
- Handshake:
  - Input transfer when in_usr_valid & in_usr_ready.
  - Output transfer when out_usr_valid & out_usr_ready.
  - Output is a single registered holding stage. Once asserted, out_usr_valid, data, sop, eop and empty stay stable until transferred.
  - in_usr_ready = (state==RUN) & (!out_usr_valid | out_usr_ready). Combinational from out_usr_ready only.
- Compaction:
  - On an accepted beat, the nonzero slots are taken in ascending slot order, m = count (0..8).
  - They are appended after the r residue slots held from earlier beats (r = 0..7), giving t = r + m.
- Emission on an accepted non-eop beat:
  - t ≥ 8: load the first 8 slots into the output register with out_usr_valid=1, empty=0. The remaining t−8 become the new residue.
  - t < 8: nothing is emitted; residue = t.
- Emission on an accepted eop beat:
  - t = 0: emit one beat, data=0, empty=0, eop=1. Zero-rule packets must stay visible downstream.
  - 1 ≤ t ≤ 8: emit one beat of t slots, eop=1, empty=2×(8−t). Unused upper slots are zero.
  - t > 8: emit 8 slots (eop=0) and go to FLUSH. The t−8 leftover slots wait.
  - In every case the residue is then cleared.
- State FLUSH:
  - in_usr_ready = 0.
  - When the pending output beat is transferred, load the leftover t−8 slots with eop=1 and empty=2×(16−t), then return to RUN.
- out_usr_sop: 1 on the first beat emitted after reset or after an emitted eop beat, else 0. Input sop is not used for framing (framing derives from eop).
- Latency: an accepted beat that completes an output beat produces out_usr_valid on the next clk edge (1 cycle).
- Throughput: one beat per cycle when out_usr_ready is held high, except one lost input cycle per packet with t > 8 at eop.
- Counters: on an accepted beat, rule_cnt += m and pkt_cnt += in_usr_eop. Both wrap modulo 2^32.
- Bubbles (in_usr_valid=0) leave the residue untouched. No timeout flush exists; only eop flushes.
- Backpressure: with out_usr_ready=0, a loaded output holds indefinitely and in_usr_ready=0. Nothing is dropped or reordered.

Test Plan:
- Single beat, sop+eop, slots {0x0005,0,0x0007,0,0,0,0,0x0009}: one output beat, data slots {5,7,9,0…}, sop=eop=1, empty=10, rule_cnt=3, pkt_cnt=1.
- 3-beat packet with 5, 5, 0 nonzero slots, and an eop beat of all zeros:
  - Beat 2 produces out beat 1: 8 rules, sop=1, eop=0, empty=0.
  - The eop beat flushes 2 rules: eop=1, empty=12.
- Packet whose eop beat gives t=13 (5 residue + 8 new):
  - Full beat (eop=0) is followed by a FLUSH beat of 5 rules, eop=1, empty=6.
  - in_usr_ready is low for exactly one cycle with out_usr_ready=1.
- Zero-rule packet, 2 all-zero beats: exactly one output beat, data=0, sop=eop=1, empty=0; rule_cnt unchanged.
- Random out_usr_ready (50% duty) over 200 random packets: output beats stable while stalled; scoreboard of rule order and count per packet matches input exactly.
- rst asserted mid-packet with residue=3 and out_usr_valid=1: outputs drop to 0 asynchronously; the next packet after release starts with sop=1 and carries no stale rules.
